// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the iterative ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_MULU = 3'b001,
        OP_OR   = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_DIVU = 3'b101,
        OP_SLTU = 3'b110,
        OP_SLT  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/iter_muldiv.sv
// Bit-serial unsigned multiply (shift-add) and restoring divide, one bit per cycle.
// done rises in the last busy cycle; res_lo/res_hi then carry the final-step result.
module iter_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             busy_q, busy_d;
    logic             div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH:0]   sum, shifted, trial;

    always_comb begin
        busy_d  = busy_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        sum     = hi_q + {1'b0, opnd_q};
        shifted = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        trial   = shifted - {1'b0, opnd_q};
        done    = busy_q && (cnt_q == LAST);

        if (start) begin
            busy_d = 1'b1;
            div_d  = is_div;
            cnt_d  = '0;
            hi_d   = '0;
            lo_d   = is_div ? a : b;
            opnd_d = is_div ? b : a;
        end else if (busy_q) begin
            if (div_q) begin
                // A borrow out of the trial subtraction means the divisor did not fit.
                if (trial[WIDTH]) begin
                    hi_d = shifted;
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end else begin
                    hi_d = trial;
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end
            end else if (lo_q[0]) begin
                {hi_d, lo_d} = {1'b0, sum, lo_q[WIDTH-1:1]};
            end else begin
                {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (done) begin
                busy_d = 1'b0;
            end
        end

        res_lo = lo_d;
        res_hi = hi_d[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
        end else begin
            busy_q <= busy_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
        end
    end

endmodule

// File: rtl/iter_alu.sv
// Valid/ready ALU: single-cycle arithmetic/logic/compare plus iterative MULU/DIVU.
// Results are registered and held in DONE until the consumer handshakes.
module iter_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic             overflow,
    output logic             zero
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d, y_hi_q, y_hi_d;
    logic             ovf_q, ovf_d, zero_q, zero_d;
    op_e              op_sel;
    logic             accept, md_start, md_done;
    logic [WIDTH-1:0] md_lo, md_hi, sum, diff;

    assign op_sel   = op_e'(op);
    assign accept   = in_valid && (state_q == ST_IDLE);
    assign md_start = accept && ((op_sel == OP_MULU) || (op_sel == OP_DIVU));

    iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .is_div (op_sel == OP_DIVU),
        .a      (a),
        .b      (b),
        .done   (md_done),
        .res_lo (md_lo),
        .res_hi (md_hi)
    );

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        y_hi_d  = y_hi_q;
        ovf_d   = ovf_q;
        sum     = a + b;
        diff    = a - b;

        case (state_q)
            ST_IDLE: begin
                if (md_start) begin
                    state_d = ST_BUSY;
                end else if (accept) begin
                    state_d = ST_DONE;
                    y_hi_d  = '0;
                    ovf_d   = 1'b0;
                    case (op_sel)
                        OP_ADD: begin
                            y_d   = sum;
                            ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                        end
                        OP_SUB: begin
                            y_d   = diff;
                            ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
                        end
                        OP_AND:  y_d = a & b;
                        OP_OR:   y_d = a | b;
                        OP_SLT:  y_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                        OP_SLTU: y_d = {{(WIDTH-1){1'b0}}, (a < b)};
                        default: y_d = '0;
                    endcase
                end
            end
            ST_BUSY: begin
                if (md_done) begin
                    state_d = ST_DONE;
                    y_d     = md_lo;
                    y_hi_d  = md_hi;
                    ovf_d   = 1'b0;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        zero_d = (y_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
            y_hi_q  <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            y_hi_q  <= y_hi_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign y         = y_q;
    assign y_hi      = y_hi_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu: directed corner cases, reset abort, random ops
// against an arithmetic reference model, and a WIDTH=8 multiply/divide run.
module tb_iter_alu;
    import alu_pkg::*;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, overflow, zero;
    logic [31:0] a, b, y, y_hi;
    logic [2:0]  op;
    logic        in_valid8, in_ready8, out_valid8, out_ready8, overflow8, zero8;
    logic [7:0]  a8, b8, y8, y_hi8;
    logic [2:0]  op8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iter_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .y_hi(y_hi), .overflow(overflow), .zero(zero)
    );

    iter_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
        .y(y8), .y_hi(y_hi8), .overflow(overflow8), .zero(zero8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from plain integer arithmetic on 64-bit values.
    function automatic void model(input logic [2:0] opc, input logic [31:0] ma, input logic [31:0] mb,
                                  output logic [31:0] ey, output logic [31:0] ehi,
                                  output logic eovf, output int elat);
        longint          sa = longint'($signed(ma));
        longint          sb = longint'($signed(mb));
        longint unsigned ua = 64'(ma);
        longint unsigned ub = 64'(mb);
        longint          r;
        longint unsigned p;
        ey = '0; ehi = '0; eovf = 1'b0; elat = 1;
        case (op_e'(opc))
            OP_ADD: begin r = sa + sb; ey = 32'(ua + ub); eovf = (r > SMAX) || (r < SMIN); end
            OP_SUB: begin r = sa - sb; ey = 32'(ua - ub); eovf = (r > SMAX) || (r < SMIN); end
            OP_AND:  ey = ma & mb;
            OP_OR:   ey = ma | mb;
            OP_SLT:  ey = (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU: ey = (ua < ub) ? 32'd1 : 32'd0;
            OP_MULU: begin p = ua * ub; ey = p[31:0]; ehi = p[63:32]; elat = 33; end
            OP_DIVU: begin
                elat = 33;
                if (mb == 32'd0) begin ey = '1; ehi = ma; end
                else begin ey = 32'(ua / ub); ehi = 32'(ua % ub); end
            end
            default: ;
        endcase
    endfunction

    task automatic do_op(input logic [2:0] o, input logic [31:0] oa, input logic [31:0] ob,
                         input int hold, input bit rel);
        logic [31:0] ey, ehi;
        logic        eovf;
        int          elat, lat;
        model(o, oa, ob, ey, ehi, eovf, elat);
        @(negedge clk);
        if (rel) rst_n = 1'b1;
        check("in_ready_idle", 64'(in_ready), 64'(1));
        in_valid = 1'b1; a = oa; b = ob; op = o;
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            in_valid = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check("latency", 64'(lat), 64'(elat));
        check("y", 64'(y), 64'(ey));
        check("y_hi", 64'(y_hi), 64'(ehi));
        check("overflow", 64'(overflow), 64'(eovf));
        check("zero", 64'(zero), 64'(ey == 32'd0));
        check("in_ready_done", 64'(in_ready), 64'(0));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            a = $urandom; b = $urandom;
            @(posedge clk); #1;
            check("hold_valid", 64'(out_valid), 64'(1));
            check("hold_ready", 64'(in_ready), 64'(0));
            check("hold_y", {y_hi, y}, {ehi, ey});
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_hs_valid", 64'(out_valid), 64'(0));
        check("post_hs_ready", 64'(in_ready), 64'(1));
        $display("op=%0d a=%08h b=%08h -> y=%08h y_hi=%08h ovf=%0b zero=%0b lat=%0d",
                 o, oa, ob, ey, ehi, eovf, ey == 32'd0, lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        bit          seen;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_y", 64'(y), 64'(0));
        check("rst_y_hi", 64'(y_hi), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        check("rst_zero", 64'(zero), 64'(1));

        // Accepted on the first rising edge after reset release.
        do_op(3'b000, 32'h7FFF_FFFF, 32'd1, 0, 1'b1);
        do_op(3'b011, 32'd5, 32'd5, 0, 1'b0);
        do_op(3'b111, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
        do_op(3'b110, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
        do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        do_op(3'b101, 32'd100, 32'd7, 10, 1'b0);
        do_op(3'b101, 32'd100, 32'd0, 0, 1'b0);
        do_op(3'b011, 32'h8000_0000, 32'd1, 2, 1'b0);

        // Reset in the middle of a multiply abandons it.
        @(negedge clk);
        in_valid = 1'b1; op = 3'b001; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'(0));
        check("abort_y", 64'(y), 64'(0));
        check("abort_y_hi", 64'(y_hi), 64'(0));
        check("abort_zero", 64'(zero), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_stale", 64'(seen), 64'(0));
        check("abort_ready", 64'(in_ready), 64'(1));

        for (int n = 0; n < 40; n++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = ra;
                2: begin ra = 32'h8000_0000; rb = 32'h7FFF_FFFF; end
                3: rb = 32'($urandom_range(1, 300));
                default: ;
            endcase
            do_op(ro, ra, rb, $urandom_range(0, 3), 1'b0);
        end

        // Narrow instance: 8-bit multiply then divide-by-zero.
        @(negedge clk);
        in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; op8 = 3'b001;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 100) begin @(posedge clk); #1; lat++; end
        check("w8_mul_latency", 64'(lat), 64'(9));
        check("w8_mul_prod", 64'({y_hi8, y8}), 64'(255 * 255));
        $display("w8 op=1 a=ff b=ff -> y=%02h y_hi=%02h lat=%0d", y8, y_hi8, lat);
        @(negedge clk); out_ready8 = 1'b1;
        @(posedge clk); #1; out_ready8 = 1'b0;
        check("w8_hs_ready", 64'(in_ready8), 64'(1));

        @(negedge clk);
        in_valid8 = 1'b1; a8 = 8'd200; b8 = 8'd0; op8 = 3'b101;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 100) begin @(posedge clk); #1; lat++; end
        check("w8_div0_latency", 64'(lat), 64'(9));
        check("w8_div0_y", 64'(y8), 64'(255));
        check("w8_div0_rem", 64'(y_hi8), 64'(200));
        $display("w8 op=5 a=c8 b=00 -> y=%02h y_hi=%02h lat=%0d", y8, y_hi8, lat);
        @(negedge clk); out_ready8 = 1'b1;
        @(posedge clk); #1; out_ready8 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width in bits, legal range 8..64.
REQ-002 Port clk  input  1  the single clock; all state SHALL change on its rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port in_valid  input  1  operation request.
REQ-005 Port in_ready  output  1  block accepts a request this cycle.
REQ-006 Port a  input  WIDTH  operand A.
REQ-007 Port b  input  WIDTH  operand B.
REQ-008 Port op  input  3  opcode: 000 ADD, 011 SUB, 100 AND, 010 OR, 111 SLT (signed), 110 SLTU, 001 MULU, 101 DIVU.
REQ-009 Port out_valid  output  1  result available.
REQ-010 Port out_ready  input  1  consumer takes the result this cycle.
REQ-011 Port y  output  WIDTH  primary result: ADD/SUB/logic/compare value, MULU low half, DIVU quotient.
REQ-012 Port y_hi  output  WIDTH  MULU high half, DIVU remainder, zero for all other ops.
REQ-013 Port overflow  output  1  signed overflow for ADD/SUB, zero for all other ops.
REQ-014 Port zero  output  1  high when y equals zero.

Function
REQ-015 A request SHALL be accepted on a cycle where in_valid and in_ready are both high; a, b and op SHALL be captured then and ignored afterwards.
REQ-016 States SHALL be IDLE, BUSY, DONE; in_ready SHALL be high only in IDLE.
REQ-017 Single-cycle ops (ADD, SUB, AND, OR, SLT, SLTU): IDLE -> DONE on acceptance; out_valid high exactly 1 cycle after acceptance.
REQ-018 MULU/DIVU: IDLE -> BUSY on acceptance; BUSY SHALL last exactly WIDTH cycles (one bit per cycle: shift-add multiply, restoring divide); BUSY -> DONE; out_valid high WIDTH+1 cycles after acceptance.
REQ-019 DONE: out_valid high and y, y_hi, overflow, zero stable until the cycle out_valid and out_ready are both high; DONE -> IDLE on that cycle.
REQ-020 No new request SHALL be accepted in the same cycle as a result handshake (in_ready low in DONE).
REQ-021 ADD/SUB SHALL wrap modulo 2^WIDTH; overflow SHALL be set when operand signs make the two's-complement result sign incorrect.
REQ-022 SLT/SLTU SHALL produce 1 or 0 in y, compared signed/unsigned respectively.
REQ-023 MULU SHALL produce the full unsigned 2*WIDTH product as {y_hi, y}.
REQ-024 DIVU with b nonzero SHALL produce unsigned quotient in y and remainder in y_hi.
REQ-025 DIVU with b equal to zero SHALL produce y all-ones and y_hi equal to a, taking the full WIDTH cycles, no other flag.
REQ-026 in_valid during BUSY or DONE SHALL have no effect on state or results.
REQ-027 Result outputs SHALL be driven from registers, not combinationally from a, b or op.

Reset
REQ-028 While rst_n is low: state IDLE, in_ready 1 after release, out_valid 0, y 0, y_hi 0, overflow 0, zero 1.
REQ-029 Reset asserted during BUSY or DONE SHALL abandon the operation; no result for it SHALL ever appear.
REQ-030 First acceptance SHALL be possible on the first rising edge with rst_n high.

Structure
REQ-031 A shared package alu_pkg SHALL hold the opcode enum (3-bit values above) and the state enum.
REQ-032 The iterative multiply/divide datapath SHALL be one sub-module, iter_muldiv, with start/done and WIDTH parameter; iter_alu holds the FSM and single-cycle ops.

Verification
REQ-033 WIDTH=32, ADD a=0x7FFFFFFF b=1 -> y=0x80000000, overflow=1, zero=0, out_valid 1 cycle after accept.
REQ-034 SUB a=5 b=5 -> y=0, zero=1, overflow=0; SLT a=0xFFFFFFFF b=1 -> y=1; SLTU same operands -> y=0.
REQ-035 MULU a=0xFFFFFFFF b=0xFFFFFFFF -> y_hi=0xFFFFFFFE, y=0x00000001, out_valid exactly 33 cycles after accept.
REQ-036 DIVU a=100 b=7 -> y=14, y_hi=2; DIVU a=100 b=0 -> y=0xFFFFFFFF, y_hi=100.
REQ-037 out_ready held low 10 cycles after out_valid -> outputs stable, in_ready low, in_valid pulses ignored; handshake -> IDLE next cycle.
REQ-038 rst_n low mid-BUSY of MULU -> out_valid 0, outputs reset values, no stale result after release; WIDTH=8 rerun of REQ-035 with 0xFF -> {0xFE,0x01}, 9-cycle latency.
